// File: rtl/ysyx_22040088_ifu.sv
// ysyx_22040088_ifu - instruction fetch unit for a single-issue, non-pipelined core.
//
// Holds the architectural PC and fetches one instruction per PC over a
// valid/ready request/response memory interface. It presents the fetched
// instruction to decode and then waits for the committed next PC.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   nextpc_i/_valid_i  committed next PC (only sampled in COMMIT)
//   imem_req_*         fetch request (valid/ready, address = PC)
//   imem_resp_*        fetch response (valid, instruction data)
//   inst_valid_o/inst_ready_i/inst_o/pc_o  instruction handoff to decode
//   fault_o            sticky misaligned-PC fault
//   fetch_cnt_o        number of instructions accepted by decode (wraps)
module ysyx_22040088_ifu #(
   parameter logic [63:0] RESET_PC = 64'h8000_0000,
   parameter int unsigned INST_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [63:0]       nextpc_i,
   input  logic              nextpc_valid_i,
   output logic              imem_req_valid_o,
   input  logic              imem_req_ready_i,
   output logic [63:0]       imem_addr_o,
   input  logic              imem_resp_valid_i,
   input  logic [INST_W-1:0] imem_resp_data_i,
   output logic              inst_valid_o,
   input  logic              inst_ready_i,
   output logic [INST_W-1:0] inst_o,
   output logic [63:0]       pc_o,
   output logic              fault_o,
   output logic [63:0]       fetch_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_OUT,
      S_COMMIT,
      S_FAULT
   } state_t;

   state_t              state;
   logic [63:0]         pc;
   logic [INST_W-1:0]   inst;
   logic                fault;
   logic [63:0]         fetch_cnt;
   logic                pc_misaligned;

   assign pc_misaligned = (pc[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         pc        <= RESET_PC;
         inst      <= '0;
         fault     <= 1'b0;
         fetch_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               state <= S_REQ;
            end
            S_REQ: begin
               // A misaligned PC never reaches memory; the request is suppressed.
               if (pc_misaligned) begin
                  state <= S_FAULT;
                  fault <= 1'b1;
               end else if (imem_req_ready_i) begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_resp_valid_i) begin
                  inst  <= imem_resp_data_i;
                  state <= S_OUT;
               end
            end
            S_OUT: begin
               if (inst_ready_i) begin
                  fetch_cnt <= fetch_cnt + 64'd1;
                  state     <= S_COMMIT;
               end
            end
            S_COMMIT: begin
               if (nextpc_valid_i) begin
                  pc    <= nextpc_i;
                  state <= S_REQ;
               end
            end
            S_FAULT: begin
               state <= S_FAULT;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Outputs depend on registered state only.
   assign imem_req_valid_o = (state == S_REQ) && !pc_misaligned;
   assign imem_addr_o      = pc;
   assign inst_valid_o     = (state == S_OUT);
   assign inst_o           = inst;
   assign pc_o             = pc;
   assign fault_o          = fault;
   assign fetch_cnt_o      = fetch_cnt;

endmodule

// File: tb/tb_ysyx_22040088_ifu.sv
// tb_ysyx_22040088_ifu - self-checking bench for the instruction fetch unit.
//
// A small instruction-memory model answers accepted requests; a table of
// per-instruction records drives stalls and next PCs, and a scoreboard queue
// holds the expected {pc, inst} from request acceptance until decode handoff.
// Reset, mid-WAIT reset and misaligned-PC fault are hand-written sequences.
module tb_ysyx_22040088_ifu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] nextpc = '0;
   logic        nextpc_valid = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [63:0] imem_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [63:0] pc;
   logic        fault;
   logic [63:0] fetch_cnt;

   int unsigned checks = 0;
   int unsigned errors = 0;

   ysyx_22040088_ifu #(
      .RESET_PC (64'h8000_0000),
      .INST_W   (32)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .nextpc_i          (nextpc),
      .nextpc_valid_i    (nextpc_valid),
      .imem_req_valid_o  (imem_req_valid),
      .imem_req_ready_i  (imem_req_ready),
      .imem_addr_o       (imem_addr),
      .imem_resp_valid_i (imem_resp_valid),
      .imem_resp_data_i  (imem_resp_data),
      .inst_valid_o      (inst_valid),
      .inst_ready_i      (inst_ready),
      .inst_o            (inst),
      .pc_o              (pc),
      .fault_o           (fault),
      .fetch_cnt_o       (fetch_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned req_stall;
      int unsigned resp_delay;
      int unsigned out_stall;
      logic [63:0] pc;
      logic [63:0] next_pc;
      logic [31:0] exp_inst;
      logic [63:0] exp_cnt;
   } vec_t;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
   } sb_t;

   vec_t vecs[6];
   sb_t  sb[$];

   function automatic logic [31:0] mem_model(input logic [63:0] addr);
      return addr[31:0] ^ 32'h8000_0413;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_inst(input vec_t v);
      int unsigned n;
      logic [31:0] rdata;
      sb_t         e;
      n = 0;
      while (!imem_req_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_seen", {63'd0, imem_req_valid}, 64'd1);
      check("req_addr", imem_addr, v.pc);
      imem_req_ready = 1'b0;
      for (int unsigned i = 0; i < v.req_stall; i++) begin
         @(negedge clk);
         check("req_hold_valid", {63'd0, imem_req_valid}, 64'd1);
         check("req_hold_addr", imem_addr, v.pc);
      end
      imem_req_ready = 1'b1;
      rdata = mem_model(imem_addr);
      sb.push_back('{pc: v.pc, inst: v.exp_inst});
      @(negedge clk);
      imem_req_ready = 1'b0;
      check("wait_no_req", {63'd0, imem_req_valid}, 64'd0);
      for (int unsigned i = 0; i < v.resp_delay; i++) begin
         @(negedge clk);
         check("wait_no_out", {63'd0, inst_valid}, 64'd0);
      end
      imem_resp_valid = 1'b1;
      imem_resp_data  = rdata;
      @(negedge clk);
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'hDEAD_BEEF;
      check("out_valid", {63'd0, inst_valid}, 64'd1);
      // Stray response and next-PC pulses while decode stalls must be ignored.
      for (int unsigned i = 0; i < v.out_stall; i++) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = 32'hFFFF_FFFF;
         nextpc_valid    = 1'b1;
         nextpc          = 64'h9000_0000;
         @(negedge clk);
         check("stall_valid", {63'd0, inst_valid}, 64'd1);
         check("stall_inst", {32'd0, inst}, {32'd0, v.exp_inst});
         check("stall_pc", pc, v.pc);
      end
      imem_resp_valid = 1'b0;
      inst_ready      = 1'b1;
      nextpc_valid    = 1'b1;
      nextpc          = 64'h9000_0000;
      if (sb.size() == 0) begin
         check("sb_nonempty", 64'd0, 64'd1);
      end else begin
         e = sb.pop_front();
         check("out_inst", {32'd0, inst}, {32'd0, e.inst});
         check("out_pc", pc, e.pc);
      end
      @(negedge clk);
      inst_ready   = 1'b0;
      nextpc_valid = 1'b0;
      check("fetch_cnt", fetch_cnt, v.exp_cnt);
      check("commit_no_out", {63'd0, inst_valid}, 64'd0);
      @(negedge clk);
      check("commit_pc_hold", pc, v.pc);
      check("commit_no_req", {63'd0, imem_req_valid}, 64'd0);
      nextpc       = v.next_pc;
      nextpc_valid = 1'b1;
      @(negedge clk);
      nextpc_valid = 1'b0;
      check("new_pc", pc, v.next_pc);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_req"}, {63'd0, imem_req_valid}, 64'd0);
      check({tag, "_out"}, {63'd0, inst_valid}, 64'd0);
      check({tag, "_fault"}, {63'd0, fault}, 64'd0);
      check({tag, "_pc"}, pc, 64'h8000_0000);
      check({tag, "_cnt"}, fetch_cnt, 64'd0);
      check({tag, "_inst"}, {32'd0, inst}, 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      //          req  resp out  pc                next_pc           inst          cnt
      vecs[0] = '{0,   0,   0,   64'h8000_0000,    64'h8000_0004,    32'h0000_0413, 64'd1};
      vecs[1] = '{0,   0,   0,   64'h8000_0004,    64'h8000_0008,    32'h0000_0417, 64'd2};
      vecs[2] = '{1,   2,   0,   64'h8000_0008,    64'h8000_000C,    32'h0000_041B, 64'd3};
      vecs[3] = '{0,   0,   3,   64'h8000_000C,    64'h8000_0010,    32'h0000_041F, 64'd4};
      vecs[4] = '{5,   0,   0,   64'h8000_0000,    64'h8000_0002,    32'h0000_0413, 64'd1};
      vecs[5] = '{0,   1,   1,   64'h8000_0000,    64'h8000_0004,    32'h0000_0413, 64'd1};

      // Power-on reset, then first request exactly one cycle after release.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;
      @(negedge clk);
      check("first_req", {63'd0, imem_req_valid}, 64'd1);
      imem_req_ready = 1'b1;

      for (int i = 0; i < 4; i++) run_inst(vecs[i]);

      // Reset while waiting for the response of the fetch at 80000010.
      check("pre_rst_req", {63'd0, imem_req_valid}, 64'd1);
      check("pre_rst_addr", imem_addr, 64'h8000_0010);
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      check("pre_rst_wait", {63'd0, imem_req_valid}, 64'd0);
      rst = 1'b1;
      @(negedge clk);
      check_reset_state("wait_rst");
      sb.delete();
      rst = 1'b0;
      @(negedge clk);
      check("restart_req", {63'd0, imem_req_valid}, 64'd1);
      check("restart_addr", imem_addr, 64'h8000_0000);

      // Long request stall, then commit a misaligned next PC.
      run_inst(vecs[4]);
      check("mis_no_req", {63'd0, imem_req_valid}, 64'd0);
      check("mis_fault_0", {63'd0, fault}, 64'd0);
      imem_req_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         nextpc_valid    = 1'b1;
         nextpc          = 64'h8000_0100;
         imem_resp_valid = 1'b1;
         @(negedge clk);
         check("fault_sticky", {63'd0, fault}, 64'd1);
         check("fault_no_req", {63'd0, imem_req_valid}, 64'd0);
         check("fault_no_out", {63'd0, inst_valid}, 64'd0);
         check("fault_pc", pc, 64'h8000_0002);
      end
      nextpc_valid    = 1'b0;
      imem_resp_valid = 1'b0;
      imem_req_ready  = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check_reset_state("fault_rst");
      rst = 1'b0;
      @(negedge clk);
      check("post_fault_req", {63'd0, imem_req_valid}, 64'd1);

      run_inst(vecs[5]);
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_22040088_ifu.md
Name: ysyx_22040088_ifu

Overview:
Instruction fetch unit. It holds the architectural PC and fetches one 32-bit instruction per PC from instruction memory over a valid/ready request/response interface. It presents the fetched instruction to decode and then waits for the next-PC selector to deliver the committed next PC. The core is single-issue and non-pipelined: exactly one instruction is in flight between fetch and commit.

Parameters:
RESET_PC, 64'h80000000, PC value loaded on reset; it matches the next-PC selector default.
INST_W, 32, instruction width in bits.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
nextpc_i  input  64  committed next PC from the next-PC selector
nextpc_valid_i  input  1  nextpc_i is valid for the current instruction; sampled only in state COMMIT
imem_req_valid_o  output  1  fetch request valid
imem_req_ready_i  input  1  memory accepts the request
imem_addr_o  output  64  fetch address; equals the PC register
imem_resp_valid_i  input  1  fetch data valid
imem_resp_data_i  input  INST_W  fetched instruction
inst_valid_o  output  1  instruction presented to decode
inst_ready_i  input  1  decode accepts the instruction
inst_o  output  INST_W  latched instruction
pc_o  output  64  PC of inst_o; equals the PC register
fault_o  output  1  sticky misaligned-PC fault
fetch_cnt_o  output  64  count of instructions handed to decode

Behaviour:
- Reset (rst=1 at an edge): state<=IDLE, pc<=RESET_PC, inst<=0, fault<=0, fetch_cnt<=0.
  - All valid outputs are 0 while in IDLE.
  - imem is reset by the same rst, so no stale response can arrive after reset.
- Reset mid-operation, in any state: same as above. Any outstanding request or response is abandoned.
- States and transitions:
  - IDLE -> REQ unconditionally. The first imem_req_valid_o is in the 1st cycle after rst deasserts.
  - REQ: imem_req_valid_o=1, imem_addr_o=pc.
    - If pc[1:0]!=0: no request is issued (valid forced 0); go to FAULT.
    - Otherwise, on imem_req_valid_o & imem_req_ready_i go to WAIT.
    - Valid and addr stay stable until accepted; valid is never withdrawn.
  - WAIT: on imem_resp_valid_i, inst<=imem_resp_data_i and go to OUT.
    - The response is accepted no earlier than the cycle after request acceptance.
    - imem_resp_valid_i is ignored in every state except WAIT.
  - OUT: inst_valid_o=1; inst_o and pc_o are stable.
    - On inst_ready_i: fetch_cnt<=fetch_cnt+1 (wraps at 2^64) and go to COMMIT.
  - COMMIT: wait for nextpc_valid_i.
    - On nextpc_valid_i: pc<=nextpc_i and go to REQ.
    - nextpc_valid_i in any other state is ignored, including when it coincides with the OUT handshake.
  - FAULT: fault_o=1. All valids are 0. Remains in FAULT until reset.
- Outputs are decoded from registered state only; there is no combinational path from inputs to outputs.
- Minimum loop, with memory ready and response immediate: REQ, WAIT, OUT, COMMIT = 4 cycles per instruction.
- The PC is 64-bit with no arithmetic here; the PC+4 add is done downstream in the selector.

Test Plan:
1. Release reset with imem ready=1 and 1-cycle response data 32'h00000413 -> req_valid in cycle 1 with addr 80000000; inst_valid with inst_o 00000413 and pc_o 80000000; after inst_ready, fetch_cnt_o=1.
2. In COMMIT drive nextpc_i=80000004 with valid -> next request addr 80000004. Repeat 3 instructions -> fetch_cnt_o=4 and addresses in sequence.
3. Hold imem_req_ready_i=0 for 5 cycles -> req_valid stays 1 and addr stays 80000000 throughout; WAIT is entered only after ready.
4. Hold inst_ready_i low for 3 cycles; pulse imem_resp_valid_i and nextpc_valid_i during OUT -> inst_o unchanged, pc unchanged, no state change.
5. nextpc_i=80000002 in COMMIT -> REQ issues no request; fault_o=1 from the next cycle and stays set. Then assert rst -> fault_o=0 and pc=80000000.
6. Assert rst during WAIT while pc=80000010 -> pc=80000000, fetch_cnt_o=0, and the fetch restarts cleanly.
